mux_select_sequencer: RTL and testbench
=======================================

Name: mux_select_sequencer

Overview:
- Control stage that sits directly upstream and downstream of the 32-bit 4:1 multiplexer.
- Arbitrates among four requesting sources (a, b, c, d) and drives the mux selects s1/s0.
- Registers the mux output y and presents it downstream with a valid/ready handshake.
- Acknowledges the granted source once the word has been accepted.

Parameters:
- WIDTH, 32, data width of y and out_data.
- SRC_N, 4, number of sources; fixed at 4 because the selects are 2 bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req  input  4  request per source; bit0=a, bit1=b, bit2=c, bit3=d; level-held until ack.
- y  input  WIDTH  combinational output of the 4:1 mux.
- s1  output  1  mux select, high bit.
- s0  output  1  mux select, low bit.
- grant  output  4  one-hot current grant; same bit order as req.
- ack  output  4  one-cycle pulse to the granted source when its word is accepted.
- out_data  output  WIDTH  captured word.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts out_data when out_valid && out_ready.

Behaviour:
- Mux select encoding {s1,s0}, fixed by the mux: a=00, c=01, b=10, d=11. The sequencer translates the grant index to this encoding; it is not a binary index.
- Reset (async, rst=1): state=IDLE, s1=0, s0=0, grant=0, ack=0, out_data=0, out_valid=0, rr pointer=0 (source a has highest priority).
- IDLE:
  - If req!=0, pick a winner starting at the rr pointer and rotating a,b,c,d.
  - Register grant and {s1,s0}, then go to SETTLE.
  - If req==0, stay in IDLE; grant=0 and selects hold their last value.
- SETTLE: one cycle for y to settle through the mux. Capture y into out_data at the end of this cycle, set out_valid=1, go to HOLD.
- HOLD:
  - out_data and the selects are frozen. out_valid stays 1 until out_ready.
  - On out_valid && out_ready: out_valid=0, ack[granted]=1 for exactly one cycle, rr pointer=(granted index+1) mod 4, grant=0, go to IDLE.
- Latency: req asserted in IDLE gives out_valid 2 cycles later (IDLE->SETTLE->HOLD). A word is accepted no sooner than the cycle out_valid is seen; ack is registered, so it appears the cycle after acceptance.
- Throughput: at most one word per 3 cycles.
- Requests sampled only in IDLE:
  - A req change during SETTLE/HOLD does not alter grant.
  - If the granted source drops req mid-transfer, the transfer still completes and ack still pulses.
- Simultaneous requests: the rotating priority guarantees each requester is served within 4 transfers.
- Wrap-around: the rr pointer after d (index 3) returns to a (index 0).
- out_ready held high in SETTLE has no effect; acceptance happens only in HOLD.
- Reset mid-operation clears everything asynchronously. The in-flight word is discarded and no ack is issued.
- Illegal state encodings recover to IDLE.

Optional Feature:
- Macro: MUX_SEQ_RR_PRIORITY_EN.
- Defined: round-robin arbitration as described above.
- Undefined: fixed priority a > b > c > d; the rr pointer logic is removed and all else is identical.
- Benches must run both builds.

Test Plan:
- Reset: rst=1 mid-HOLD with out_valid=1 -> next observation out_valid=0, grant=0, s1=0, s0=0, ack=0, out_data=0.
- Single source: req=0100 (c) with y driven as 32'h0000_0100 for select 01 -> s1=0, s0=1 in SETTLE; out_data=32'h0000_0100, out_valid=1 two cycles after req; with out_ready=1, ack=0100 for one cycle.
- Round-robin: req=1111 held, out_ready=1, pointer starts at a -> grants a, b, c, d, a in order; selects 00, 10, 01, 11, 00; each ack one cycle wide. With the macro undefined -> a granted every time.
- Backpressure: req=0010 (b), out_ready=0 for 5 cycles after out_valid -> out_data=32'h0000_0010 and {s1,s0}=10 stable, no ack; out_ready=1 -> ack=0010 next cycle, out_valid=0.
- Request drop: req=1000 (d) granted, req deasserted in SETTLE -> transfer completes, out_data=32'h0000_1000, ack=1000 still pulses; IDLE afterwards with grant=0.
- Idle: req=0000 for 10 cycles -> out_valid=0, ack=0, grant=0 throughout.

Source files
------------

// File: rtl/mux_select_sequencer.sv
// Arbitrates four sources onto a 32-bit 4:1 mux, registers y and hands it downstream with valid/ready.
// Build option MUX_SEQ_RR_PRIORITY_EN: defined = round-robin arbitration, undefined = fixed priority a>b>c>d.
module mux_select_sequencer #(
  parameter int WIDTH = 32,
  parameter int SRC_N = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SRC_N-1:0] req,
  input  logic [WIDTH-1:0] y,
  output logic             s1,
  output logic             s0,
  output logic [SRC_N-1:0] grant,
  output logic [SRC_N-1:0] ack,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [SRC_N-1:0] grant_q, grant_d;
  logic [SRC_N-1:0] ack_q, ack_d;
  logic [1:0]       sel_q, sel_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;

  logic [1:0]       arb_base;
  logic [1:0]       win_idx;
  logic             win_found;

`ifdef MUX_SEQ_RR_PRIORITY_EN
  logic [1:0]       rr_ptr_q, rr_ptr_d;
  assign arb_base = rr_ptr_q;
`else
  assign arb_base = 2'd0;
`endif

  // Scan from the highest offset down so the source nearest arb_base wins last.
  always_comb begin
    logic [1:0] idx;
    idx       = '0;
    win_idx   = '0;
    win_found = 1'b0;
    for (int k = SRC_N - 1; k >= 0; k--) begin
      idx = arb_base + k[1:0];
      if (req[idx]) begin
        win_idx   = idx;
        win_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    sel_d       = sel_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    ack_d       = '0;
`ifdef MUX_SEQ_RR_PRIORITY_EN
    rr_ptr_d    = rr_ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_d = {{(SRC_N-1){1'b0}}, 1'b1} << win_idx;
          // Mux wiring puts b on 10 and c on 01, so the select is the index bit-swapped.
          sel_d   = {win_idx[0], win_idx[1]};
          state_d = SETTLE;
        end else begin
          grant_d = '0;
        end
      end
      SETTLE: begin
        out_data_d  = y;
        out_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          ack_d       = grant_q;
          grant_d     = '0;
          state_d     = IDLE;
`ifdef MUX_SEQ_RR_PRIORITY_EN
          rr_ptr_d    = {grant_q[3] | grant_q[2], grant_q[3] | grant_q[1]} + 2'd1;
`endif
        end
      end
      default: begin
        state_d     = IDLE;
        grant_d     = '0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      ack_q       <= '0;
      sel_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
`ifdef MUX_SEQ_RR_PRIORITY_EN
      rr_ptr_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      ack_q       <= ack_d;
      sel_q       <= sel_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
`ifdef MUX_SEQ_RR_PRIORITY_EN
      rr_ptr_q    <= rr_ptr_d;
`endif
    end
  end

  assign s1        = sel_q[1];
  assign s0        = sel_q[0];
  assign grant     = grant_q;
  assign ack       = ack_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_select_sequencer.sv
// Scoreboard bench for mux_select_sequencer: driver pushes predicted words, a negedge monitor pops on acceptance.
// Run once with and once without +define+MUX_SEQ_RR_PRIORITY_EN.
module tb_mux_select_sequencer;
  localparam int W = 32;

  typedef struct {
    logic [3:0]   grant;
    logic [1:0]   sel;
    logic [W-1:0] data;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   req = '0;
  logic [W-1:0] y;
  logic         s1, s0;
  logic [3:0]   grant, ack;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready = 1'b0;

  logic [W-1:0] words [4];

  int   vectors = 0;
  int   miscompares = 0;
  int   model_ptr = 0;
  exp_t exp_q[$];

  logic [3:0]   ack_exp = '0;
  logic         prev_hold = 1'b0;
  logic [W-1:0] prev_data = '0;
  logic [1:0]   prev_sel = '0;
  exp_t         mon_e;

  always #5 clk = ~clk;

  mux_select_sequencer #(.WIDTH(W), .SRC_N(4)) dut (
    .clk(clk), .rst(rst), .req(req), .y(y), .s1(s1), .s0(s0),
    .grant(grant), .ack(ack), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  // Physical 4:1 mux: 00=a, 01=c, 10=b, 11=d.
  always_comb begin
    case ({s1, s0})
      2'b00:   y = words[0];
      2'b01:   y = words[2];
      2'b10:   y = words[1];
      default: y = words[3];
    endcase
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp_v, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int ptr);
    int start;
`ifdef MUX_SEQ_RR_PRIORITY_EN
    start = ptr;
`else
    start = 0 * ptr;
`endif
    for (int k = 0; k < 4; k++) begin
      if (r[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [1:0] sel_of(input int src);
    case (src)
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b01;
      default: return 2'b11;
    endcase
  endfunction

  function automatic exp_t predict(input logic [3:0] r);
    exp_t e;
    int   w;
    w = pick(r, model_ptr);
    model_ptr = (w + 1) % 4;
    e.grant = 4'b0001 << w;
    e.sel   = sel_of(w);
    e.data  = words[w];
    return e;
  endfunction

  // One transaction from IDLE; returns with the DUT back in IDLE and req cleared.
  task automatic issue(input logic [3:0] r, input bit rand_data, input bit drop,
                       input int hold_min, input int pct);
    exp_t e;
    bit   got;
    if (rand_data) for (int i = 0; i < 4; i++) words[i] = $urandom;
    req = r;
    e = predict(r);
    exp_q.push_back(e);
    out_ready = 1'($urandom_range(1));
    @(posedge clk); #1;
    check("settle_grant", grant, e.grant);
    check("settle_sel", {s1, s0}, e.sel);
    check("settle_valid", out_valid, 0);
    req = drop ? 4'b0000 : 4'($urandom);
    @(posedge clk); #1;
    check("latency_valid", out_valid, 1);
    for (int i = 0; i < 4; i++) words[i] = $urandom;
    got = 1'b0;
    for (int c = 0; c < hold_min + 20 && !got; c++) begin
      out_ready = (c >= hold_min) && (($urandom_range(99) < pct) || (c >= hold_min + 10));
      @(posedge clk); #1;
      if (ack != 4'b0000) got = 1'b1;
    end
    out_ready = 1'b0;
    req = '0;
    if (!got) begin
      vectors++;
      miscompares++;
      $display("FAIL ack_timeout: got no ack, expected 0x%0h", e.grant);
    end
  endtask

  task automatic idle(input int n);
    req = '0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    req = '0;
    out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_grant", grant, 0);
    check("rst_sel", {s1, s0}, 0);
    check("rst_ack", ack, 0);
    check("rst_data", out_data, 0);
    exp_q.delete();
    model_ptr = 0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
  endtask

  // Monitor: acceptance is out_valid && out_ready seen here; ack must follow one edge later.
  always @(negedge clk) begin
    if (rst) begin
      ack_exp   = '0;
      prev_hold = 1'b0;
    end else begin
      check("ack", ack, ack_exp);
      ack_exp = '0;
      if (exp_q.size() == 0) begin
        check("idle_grant", grant, 0);
        check("idle_valid", out_valid, 0);
      end
      if (prev_hold && out_valid) begin
        check("hold_data", out_data, prev_data);
        check("hold_sel", {s1, s0}, prev_sel);
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      prev_sel  = {s1, s0};
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_word: got 0x%0h, expected none", out_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_data", out_data, mon_e.data);
          check("out_grant", grant, mon_e.grant);
          check("out_sel", {s1, s0}, mon_e.sel);
          ack_exp = mon_e.grant;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 4; i++) words[i] = '0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("init_valid", out_valid, 0);
    check("init_grant", grant, 0);
    check("init_data", out_data, 0);
    check("init_sel", {s1, s0}, 0);

    idle(10);

    words[0] = 32'h0000_000A; words[1] = 32'h0000_0010;
    words[2] = 32'h0000_0100; words[3] = 32'h0000_1000;
    issue(4'b0100, 1'b0, 1'b0, 0, 100);

    words[0] = 32'h0000_000A; words[1] = 32'h0000_0010;
    words[2] = 32'h0000_0100; words[3] = 32'h0000_1000;
    issue(4'b0010, 1'b0, 1'b0, 5, 100);

    words[0] = 32'h0000_000A; words[1] = 32'h0000_0010;
    words[2] = 32'h0000_0100; words[3] = 32'h0000_1000;
    issue(4'b1000, 1'b0, 1'b1, 0, 100);
    idle(3);

    do_reset();
    repeat (5) issue(4'b1111, 1'b1, 1'b0, 0, 100);

    // Reset while a word sits in HOLD: word is discarded, no ack afterwards.
    words[2] = 32'hDEAD_BEEF;
    req = 4'b0100;
    exp_q.push_back(predict(4'b0100));
    out_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_valid", out_valid, 1);
    do_reset();
    idle(4);

    for (int t = 0; t < 150; t++) begin
      issue(4'($urandom_range(1, 15)), 1'b1, ($urandom_range(3) == 0),
            $urandom_range(3), $urandom_range(20, 100));
      if ($urandom_range(3) == 0) idle($urandom_range(1, 3));
    end
    idle(5);
    check("final_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
